// File: rtl/otter_pkg.sv
// rtl/otter_pkg.sv - shared OTTER opcode, write-channel and squash-state definitions
//
// Purpose: one home for the opcode decode used by the wrong-path squash logic,
//          the write-enable channel numbering and the squash state type.
// Ports:   none (package).

package otter_pkg;

   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;

   // bit positions inside the write-enable vector
   localparam int WE_REG = 0;
   localparam int WE_MEM = 1;
   localparam int WE_CSR = 2;

   typedef enum logic {
      SQ_IDLE = 1'b0,
      SQ_KILL = 1'b1
   } squash_state_t;

   function automatic logic is_jump(input logic [6:0] op);
      return (op == JAL) || (op == JALR);
   endfunction

endpackage

// File: rtl/wrong_path_squash.sv
// rtl/wrong_path_squash.sv - kills write enables of the DEPTH instructions after a control transfer
//
// Purpose: after a JAL/JALR (optional), taken branch or trap advances, the next
//          DEPTH advancing instructions are on the wrong path; their register,
//          memory and CSR write enables are forced low. A trap also kills its
//          own writes. Stalls (advance = 0) hold the kill window open.
// Ports:
//   CLK        in  core clock, state changes on the falling edge
//   RST        in  asynchronous active-high reset
//   opcode     in  opcode of the presented instruction
//   advance    in  presented instruction leaves the stage this cycle
//   we_in      in  raw write enables (bit WE_REG, WE_MEM, WE_CSR)
//   squash     in  taken branch / mispredict resolved for this instruction
//   trap       in  trap or interrupt redirect on this instruction
//   we_out     out gated write enables
//   squashing  out current instruction is being killed
//   kill_count out kills remaining, including the current instruction

module wrong_path_squash
   import otter_pkg::*;
#(
   parameter int DEPTH          = 2,
   parameter int NUM_WE         = 2,
   parameter int SQUASH_ON_JUMP = 1
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic [6:0]                   opcode,
   input  logic                         advance,
   input  logic [NUM_WE-1:0]            we_in,
   input  logic                         squash,
   input  logic                         trap,
   output logic [NUM_WE-1:0]            we_out,
   output logic                         squashing,
   output logic [$clog2(DEPTH+1)-1:0]   kill_count
);

   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

   if (DEPTH < 1 || DEPTH > 7) begin : g_bad_depth
      $error("wrong_path_squash: DEPTH must be in 1..7");
   end
   if (NUM_WE < 1) begin : g_bad_num_we
      $error("wrong_path_squash: NUM_WE must be at least 1");
   end

   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_nxt;
   squash_state_t  state;
   logic           jump_trig;
   logic           trigger;

   assign jump_trig = (SQUASH_ON_JUMP != 0) && is_jump(opcode);
   assign trigger   = squash | trap | jump_trig;
   assign state     = (cnt == '0) ? SQ_IDLE : SQ_KILL;

   // Falling-edge update so the second half-cycle already sees the new kill window.
   always_ff @(negedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt_nxt;
      end
   end

   always_comb begin
      cnt_nxt   = cnt;
      we_out    = we_in;
      squashing = 1'b0;
      case (state)
         SQ_IDLE: begin
            // A trapping instruction must not retire its own writes.
            if (trap) begin
               we_out = '0;
            end
            // A held trigger is simply re-evaluated next cycle.
            if (trigger && advance) begin
               cnt_nxt = DEPTH_C;
            end
         end
         SQ_KILL: begin
            // Triggers here come from wrong-path instructions and are ignored.
            we_out    = '0;
            squashing = 1'b1;
            if (advance) begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         default: begin
            cnt_nxt = '0;
         end
      endcase
      if (RST) begin
         we_out = '0;
      end
   end

   assign kill_count = cnt;

endmodule

// File: tb/tb_wrong_path_squash.sv
// tb/tb_wrong_path_squash.sv - self-checking bench for wrong_path_squash

module tb_wrong_path_squash;

   localparam int DEPTH = 2;
   localparam logic [6:0] OP_NOP  = 7'b0110011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [6:0] opcode = OP_NOP;
   logic       advance = 1'b0;
   logic [1:0] we_in = 2'b00;
   logic       squash = 1'b0;
   logic       trap = 1'b0;

   logic [1:0] we_a, we_b;
   logic       sq_a, sq_b;
   logic [1:0] kc_a, kc_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 CLK = ~CLK;

   wrong_path_squash #(.DEPTH(DEPTH), .NUM_WE(2), .SQUASH_ON_JUMP(1)) dut_a (
      .CLK(CLK), .RST(RST), .opcode(opcode), .advance(advance), .we_in(we_in),
      .squash(squash), .trap(trap), .we_out(we_a), .squashing(sq_a), .kill_count(kc_a));

   wrong_path_squash #(.DEPTH(DEPTH), .NUM_WE(2), .SQUASH_ON_JUMP(0)) dut_b (
      .CLK(CLK), .RST(RST), .opcode(opcode), .advance(advance), .we_in(we_in),
      .squash(squash), .trap(trap), .we_out(we_b), .squashing(sq_b), .kill_count(kc_b));

   // Model: number the advancing instructions; an instruction is killed when its
   // number lies in the DEPTH slots after the last honoured trigger.
   int   seq      [2];
   int   tseq     [2];
   bit   have_trig[2];

   function automatic bit m_killed(input int i);
      return have_trig[i] && (seq[i] > tseq[i]) && (seq[i] <= tseq[i] + DEPTH);
   endfunction

   function automatic bit m_trigger(input int i);
      bit jumps;
      jumps = (i == 0);
      return squash || trap || (jumps && (opcode == OP_JAL || opcode == OP_JALR));
   endfunction

   always @(posedge CLK or negedge CLK) begin
      if (CLK) begin
         for (int i = 0; i < 2; i++) begin
            logic [1:0] ew, gw;
            logic       es, gs;
            int         ek;
            logic [1:0] gk;
            if (RST) begin
               have_trig[i] = 0;
               seq[i]       = 0;
            end
            ek = m_killed(i) ? (tseq[i] + DEPTH - seq[i] + 1) : 0;
            es = !RST && m_killed(i);
            ew = (RST || m_killed(i) || trap) ? 2'b00 : we_in;
            gw = (i == 0) ? we_a : we_b;
            gs = (i == 0) ? sq_a : sq_b;
            gk = (i == 0) ? kc_a : kc_b;
            n_cmp++;
            if (gw !== ew || gs !== es || gk !== 2'(ek)) begin
               n_bad++;
               $display("FAIL model_dut%0d t=%0t: got we=%b sq=%b kc=%0d, want we=%b sq=%b kc=%0d",
                        i, $time, gw, gs, gk, ew, es, ek);
            end
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (RST) begin
               have_trig[i] = 0;
               seq[i]       = 0;
            end else if (advance) begin
               if (!m_killed(i) && m_trigger(i)) begin
                  have_trig[i] = 1;
                  tseq[i]      = seq[i];
               end
               seq[i]++;
            end
         end
      end
   end

   task automatic step(input logic [6:0] op, input logic adv, input logic [1:0] we,
                       input logic sq, input logic tr, input logic rst);
      @(negedge CLK);
      #1;
      opcode  = op;
      advance = adv;
      we_in   = we;
      squash  = sq;
      trap    = tr;
      RST     = rst;
   endtask

   task automatic lit(input string name, input int inst, input logic [1:0] ew,
                      input logic es, input logic [1:0] ek);
      logic [1:0] gw, gk;
      logic       gs;
      @(posedge CLK);
      #1;
      gw = (inst == 0) ? we_a : we_b;
      gs = (inst == 0) ? sq_a : sq_b;
      gk = (inst == 0) ? kc_a : kc_b;
      n_cmp++;
      if (gw !== ew || gs !== es || gk !== ek) begin
         n_bad++;
         $display("FAIL %s: got we=%b sq=%b kc=%0d, want we=%b sq=%b kc=%0d",
                  name, gw, gs, gk, ew, es, ek);
      end
   endtask

   initial begin
      // reset holds outputs low
      step(OP_NOP, 1, 2'b11, 0, 0, 1);  lit("reset_state", 0, 2'b00, 0, 2'd0);
      step(OP_NOP, 1, 2'b11, 0, 0, 1);
      // plain pass-through
      for (int k = 0; k < 5; k++) begin
         step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("pass", 0, 2'b11, 0, 2'd0);
      end
      // JAL: own write passes, two kills, third passes
      step(OP_JAL, 1, 2'b01, 0, 0, 0);  lit("jal_self", 0, 2'b01, 0, 2'd0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("jal_kill2", 0, 2'b00, 1, 2'd2);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("jal_kill1", 0, 2'b00, 1, 2'd1);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("jal_after", 0, 2'b11, 0, 2'd0);
      // squash then a three-cycle stall inside the kill window
      step(OP_NOP, 1, 2'b11, 1, 0, 0);  lit("sq_self", 0, 2'b11, 0, 2'd0);
      for (int k = 0; k < 3; k++) begin
         step(OP_NOP, 0, 2'b11, 0, 0, 0);  lit("sq_stall", 0, 2'b00, 1, 2'd2);
      end
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("sq_kill2", 0, 2'b00, 1, 2'd2);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("sq_kill1", 0, 2'b00, 1, 2'd1);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("sq_after", 0, 2'b11, 0, 2'd0);
      // trap (with squash) kills itself; JALR in the window is ignored
      step(OP_NOP, 1, 2'b11, 1, 1, 0);  lit("trap_self", 0, 2'b00, 0, 2'd0);
      step(OP_JALR, 1, 2'b11, 0, 0, 0); lit("trap_jalr", 0, 2'b00, 1, 2'd2);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("trap_kill1", 0, 2'b00, 1, 2'd1);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("trap_after", 0, 2'b11, 0, 2'd0);
      // trigger on the expiring slot is ignored
      step(OP_JAL, 1, 2'b01, 0, 0, 0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      step(OP_JAL, 1, 2'b11, 0, 0, 0);  lit("expiry_trig", 0, 2'b00, 1, 2'd1);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("expiry_after", 0, 2'b11, 0, 2'd0);
      // back-to-back triggers DEPTH advances apart
      step(OP_NOP, 1, 2'b11, 1, 0, 0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      step(OP_NOP, 1, 2'b11, 1, 0, 0);  lit("b2b_second", 0, 2'b11, 0, 2'd0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("b2b_kill2", 0, 2'b00, 1, 2'd2);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      // trigger held under stall in IDLE
      step(OP_NOP, 0, 2'b11, 1, 0, 0);  lit("held_trig", 0, 2'b11, 0, 2'd0);
      step(OP_NOP, 0, 2'b11, 1, 0, 0);  lit("held_trig2", 0, 2'b11, 0, 2'd0);
      step(OP_NOP, 1, 2'b11, 1, 0, 0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("held_kill", 0, 2'b00, 1, 2'd2);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      // jump-blind instance: JALR is not a trigger
      step(OP_JALR, 1, 2'b01, 0, 0, 0); lit("nojump_self", 1, 2'b01, 0, 2'd0);
      step(OP_NOP, 1, 2'b01, 0, 0, 0);  lit("nojump_next", 1, 2'b01, 0, 2'd0);
      step(OP_NOP, 1, 2'b01, 0, 0, 0);  lit("nojump_next2", 1, 2'b01, 0, 2'd0);
      // reset in the middle of a kill window
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      step(OP_JAL, 1, 2'b01, 0, 0, 0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);  lit("pre_rst_kc1", 0, 2'b00, 1, 2'd1);
      step(OP_NOP, 1, 2'b11, 0, 0, 1);  lit("mid_rst", 0, 2'b00, 0, 2'd0);
      step(OP_NOP, 1, 2'b10, 0, 0, 0);  lit("post_rst", 0, 2'b10, 0, 2'd0);
      step(OP_NOP, 1, 2'b11, 0, 0, 0);
      step(OP_NOP, 0, 2'b00, 0, 0, 0);
      @(negedge CLK);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/wrong_path_squash.md
# wrong_path_squash

Parametrised wrong-path write suppressor for the pipelined OTTER core, sitting between decode/execute control and the register-file, data-memory and CSR write ports. When a control-transfer event is detected (JAL, JALR, taken branch, or trap redirect), it kills the write enables of the following DEPTH instructions that advance, so wrong-path instructions already in flight cannot change architectural state. It supersedes the fixed two-slot, two-write-enable squash logic with configurable depth, write-channel count, trigger mode and stall awareness.

## Interface
- DEPTH, 2: number of advancing instructions killed after a trigger (1..7)
- NUM_WE, 2: number of write-enable channels gated (bit 0 regWrite, bit 1 memWrite, bit 2 csrWrite when present)
- SQUASH_ON_JUMP, 1: 1 means JAL/JALR opcodes trigger; 0 means only the squash and trap inputs trigger (front end predicts jumps)

- CLK  in  1  core clock; all state updates on the falling edge
- RST  in  1  asynchronous, active-high reset
- opcode  in  7  opcode of the instruction currently presented
- advance  in  1  1 = the presented instruction leaves the stage this cycle; 0 = stalled
- we_in  in  NUM_WE  raw write enables of the presented instruction
- squash  in  1  taken branch (or mispredict) resolved for the presented instruction
- trap  in  1  trap/interrupt redirect taken on the presented instruction
- we_out  out  NUM_WE  gated write enables
- squashing  out  1  1 while the current instruction is being killed
- kill_count  out  $clog2(DEPTH+1)  remaining instructions to kill, including the current one

## Operation
- Opcodes: JAL = 7'b1101111, JALR = 7'b1100111; decode in a shared package, never duplicated.
- trigger = squash | trap | (SQUASH_ON_JUMP & (opcode == JAL | opcode == JALR)).
- Two states, IDLE and KILL, held in a counter cnt; IDLE ⇔ cnt == 0.
- IDLE: we_out = we_in; squashing = 0. If trigger & advance: the triggering instruction's own writes pass, cnt ← DEPTH, go to KILL. If trigger & !advance: no state change; the trigger is re-evaluated while the instruction is held.
- KILL: we_out = 0, squashing = 1 (combinational from cnt). On advance, cnt ← cnt − 1; at cnt == 1 with advance, return to IDLE. On !advance, cnt holds and writes stay killed.
- Triggers while in KILL come from wrong-path instructions and are ignored, including trap.
- trap has the same effect as squash. Exception: trap always uses DEPTH slots and also kills the triggering instruction's own we_in. Trap priority: when trap and squash/jump assert together, the trap behaviour applies.
- kill_count = cnt; it never exceeds DEPTH and never wraps below 0.
- Arithmetic: cnt is unsigned, with width $clog2(DEPTH+1); decrement only when cnt > 0.

## Timing
- we_out and squashing are combinational from the registered cnt and the current inputs. There is no added latency on the pass path.
- cnt updates on the falling edge of CLK, so the next half-cycle consumer sees the new kill state.
- Reset: cnt = 0 (IDLE). During reset, we_out = 0 regardless of we_in, squashing = 0, and kill_count = 0.
- RST asserted mid-KILL: cnt clears immediately (asynchronous). After deassertion, the next instruction passes.
- A trigger on the same edge that KILL expires (cnt == 1 and advance) is a wrong-path trigger and is ignored. Evaluation starts with the following instruction.
- Back-to-back triggers separated by exactly DEPTH advances: both are honoured.

## Structure
- Package otter_pkg: opcode localparams (JAL, JALR, BRANCH), the write-enable channel index constants (WE_REG = 0, WE_MEM = 1, WE_CSR = 2), and the squash state typedef.
- Single flat module. The trigger decode is small enough that no sub-module is warranted.
- Target 120–200 lines including parameter assertions (DEPTH in 1..7, NUM_WE ≥ 1).

## Test plan
- Reset, then we_in = 2'b11 with no trigger for 5 advances → we_out = 2'b11 each cycle, squashing = 0.
- JAL (1101111) with we_in = 2'b01 and advance, DEPTH = 2 → JAL's we_out = 2'b01. The next 2 advancing instructions get we_out = 2'b00 with kill_count 2 then 1. The third passes.
- squash with advance = 0 for the 3 cycles after the trigger (DEPTH = 2) → kill_count holds at 2 and we_out = 0 throughout the stall; exactly 2 advances are then killed.
- trap with we_in = 2'b11 → the trapping instruction's we_out = 2'b00, then DEPTH kills. A JALR during KILL changes nothing.
- SQUASH_ON_JUMP = 0, JALR with we_in = 2'b01 → no kill; we_out = 2'b01 on all following instructions.
- Assert RST when kill_count = 1 → kill_count = 0 and we_out = 0 during reset. After release, we_in = 2'b10 → we_out = 2'b10.
